// File: rtl/itr_ctrl.sv
// itr_ctrl: multi-source interrupt controller feeding the core's single itr input.
// Raw request lines are synchronised and edge-detected, latched as pending,
// masked and gated by a global enable, then arbitrated (fixed or round-robin)
// into a REQ -> SERV -> GAP handshake with the core.
module itr_ctrl #(
    parameter int NSRC    = 4,
    parameter int PRIO_RR = 0,
    parameter int NBID    = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic            cfg_wr,
    input  logic [1:0]      cfg_addr,
    input  logic [NSRC-1:0] cfg_data,
    output logic            itr,
    input  logic            itr_ack,
    input  logic            itr_ret,
    output logic [NBID-1:0] itr_id,
    output logic            busy,
    output logic [NSRC-1:0] pend,
    output logic [NSRC-1:0] mask
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SERV = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t          state_q;
    logic            itr_q;
    logic [NBID-1:0] itr_id_q;
    logic [NBID-1:0] rr_ptr_q;

    logic [NSRC-1:0] s1_q, s2_q, s3_q;
    logic [NSRC-1:0] src_edge;

    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            en_q, en_d;

    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] pend_clr;
    logic [NSRC-1:0] elig;
    logic            take_ack;
    logic            win_vld;
    logic [NBID-1:0] win_id;

    // Two-flop synchroniser plus a third flop so each rising level yields one edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= src;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign src_edge = s2_q & ~s3_q;

    // The acknowledge only counts while a request is actually outstanding
    assign take_ack = (state_q == S_REQ) && itr_ack;

    // Per-source clear from the grant, hitting only the acknowledged id
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_ack_clr
        assign ack_clr[gi] = take_ack && (itr_id_q == NBID'(gi));
    end

    // Next-state for pending/mask/enable; an edge overrides any clear in the same cycle
    always_comb begin
        pend_clr = ack_clr;
        if (cfg_wr && cfg_addr == 2'd1) begin
            pend_clr = pend_clr | cfg_data;
        end
        pend_d = (pend_q & ~pend_clr) | src_edge;
        mask_d = (cfg_wr && cfg_addr == 2'd0) ? cfg_data : mask_q;
        en_d   = (cfg_wr && cfg_addr == 2'd2) ? cfg_data[0] : en_q;
    end

    // Configuration and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            mask_q <= '1;
            en_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            en_q   <= en_d;
        end
    end

    assign elig = pend_q & ~mask_q & {NSRC{en_q}};

    // Winner selection: lowest index, or first index above the last grant when round-robin
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (PRIO_RR != 0) begin
                idx = (int'(rr_ptr_q) + 1 + k) % NSRC;
            end else begin
                idx = k;
            end
            if (!win_vld && elig[NBID'(idx)]) begin
                win_vld = 1'b1;
                win_id  = NBID'(idx);
            end
        end
    end

    // Request/service handshake with the core; itr and itr_id are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            itr_q    <= 1'b0;
            itr_id_q <= '0;
            rr_ptr_q <= NBID'(NSRC - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        itr_q    <= 1'b1;
                        itr_id_q <= win_id;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Request is never withdrawn; only the ack moves us on
                    if (itr_ack) begin
                        itr_q    <= 1'b0;
                        rr_ptr_q <= itr_id_q;
                        state_q  <= S_SERV;
                    end
                end
                S_SERV: begin
                    if (itr_ret) begin
                        state_q <= S_GAP;
                    end
                end
                default: begin
                    // Guaranteed quiet cycle between two services
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign itr    = itr_q;
    assign itr_id = itr_id_q;
    assign busy   = (state_q == S_REQ) || (state_q == S_SERV);
    assign pend   = pend_q;
    assign mask   = mask_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Testbench for itr_ctrl: one fixed-priority and one round-robin instance share
// the stimulus; a vector table covers the basic flow and masking, hand-written
// sequences cover arbitration order, set-wins, no-nesting and reset in service.
module tb_itr_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] src;
    logic       cfg_wr;
    logic [1:0] cfg_addr;
    logic [3:0] cfg_data;
    logic       itr_ack;
    logic       itr_ret;

    logic       itr_f, busy_f, itr_r, busy_r;
    logic [1:0] id_f, id_r;
    logic [3:0] pend_f, mask_f, pend_r, mask_r;

    int n_pass  = 0;
    int n_total = 0;

    itr_ctrl #(.NSRC(4), .PRIO_RR(0)) dut_fix (
        .clk(clk), .rst(rst), .src(src), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .itr(itr_f), .itr_ack(itr_ack), .itr_ret(itr_ret),
        .itr_id(id_f), .busy(busy_f), .pend(pend_f), .mask(mask_f)
    );

    itr_ctrl #(.NSRC(4), .PRIO_RR(1)) dut_rr (
        .clk(clk), .rst(rst), .src(src), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .itr(itr_r), .itr_ack(itr_ack), .itr_ret(itr_ret),
        .itr_id(id_r), .busy(busy_r), .pend(pend_r), .mask(mask_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [3:0] data;
        logic [3:0] s;
        logic       ack;
        logic       ret;
        logic       e_itr;
        logic [1:0] e_id;
        logic       e_busy;
        logic [3:0] e_pend;
        logic [3:0] e_mask;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic idle_inputs();
        src = '0; cfg_wr = 0; cfg_addr = '0; cfg_data = '0; itr_ack = 0; itr_ret = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cyc(2);
        rst = 0;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [3:0] d);
        cfg_wr = 1; cfg_addr = a; cfg_data = d;
        cyc(1);
        cfg_wr = 0; cfg_addr = '0; cfg_data = '0;
    endtask

    task automatic pulse_src(input logic [3:0] s);
        src = s;
        cyc(1);
        src = '0;
    endtask

    task automatic pulse_ack();
        itr_ack = 1; cyc(1); itr_ack = 0;
    endtask

    task automatic pulse_ret();
        itr_ret = 1; cyc(1); itr_ret = 0;
    endtask

    // Bounded wait for a request from the chosen instance, then check its id
    task automatic wait_itr(input bit rr, input string nm, input int exp_id);
        for (int i = 0; i < 20; i++) begin
            if ((rr ? itr_r : itr_f) == 1'b1) break;
            cyc(1);
        end
        chk({nm, "_itr"}, int'(rr ? itr_r : itr_f), 1);
        chk({nm, "_id"}, int'(rr ? id_r : id_f), exp_id);
    endtask

    task automatic addv(input logic wr, input logic [1:0] a, input logic [3:0] d,
                        input logic [3:0] s, input logic ack, input logic ret,
                        input logic ei, input logic [1:0] eid, input logic eb,
                        input logic [3:0] ep, input logic [3:0] em);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.s = s; v.ack = ack; v.ret = ret;
        v.e_itr = ei; v.e_id = eid; v.e_busy = eb; v.e_pend = ep; v.e_mask = em;
        vq.push_back(v);
    endtask

    initial begin
        rst = 1;
        idle_inputs();

        //   wr addr data    src     ack ret | itr id busy pend    mask
        addv(1, 0, 4'b0000, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 4'b0000);
        addv(1, 2, 4'b0001, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0100, 0, 0,  0, 0, 0, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0100, 0, 0,  0, 0, 0, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0100, 0, 0,  0, 0, 0, 4'b0100, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  1, 2, 1, 4'b0100, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  1, 2, 1, 4'b0100, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 1, 0,  0, 2, 1, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  0, 2, 1, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 1,  0, 2, 0, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 1, 0,  0, 2, 0, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  0, 2, 0, 4'b0000, 4'b0000);
        // masked source stays pending, unmasking raises the request
        addv(1, 0, 4'b0010, 4'b0000, 0, 0,  0, 2, 0, 4'b0000, 4'b0010);
        addv(0, 0, 4'b0000, 4'b0010, 0, 0,  0, 2, 0, 4'b0000, 4'b0010);
        addv(0, 0, 4'b0000, 4'b0010, 0, 0,  0, 2, 0, 4'b0000, 4'b0010);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  0, 2, 0, 4'b0010, 4'b0010);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  0, 2, 0, 4'b0010, 4'b0010);
        addv(1, 0, 4'b0000, 4'b0000, 0, 0,  0, 2, 0, 4'b0010, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  1, 1, 1, 4'b0010, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 1, 0,  0, 1, 1, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 1,  0, 1, 0, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  0, 1, 0, 4'b0000, 4'b0000);
        // masked pending source cleared by write-1-to-clear never requests
        addv(1, 0, 4'b0010, 4'b0000, 0, 0,  0, 1, 0, 4'b0000, 4'b0010);
        addv(0, 0, 4'b0000, 4'b0010, 0, 0,  0, 1, 0, 4'b0000, 4'b0010);
        addv(0, 0, 4'b0000, 4'b0010, 0, 0,  0, 1, 0, 4'b0000, 4'b0010);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  0, 1, 0, 4'b0010, 4'b0010);
        addv(1, 1, 4'b0010, 4'b0000, 0, 0,  0, 1, 0, 4'b0000, 4'b0010);
        addv(1, 0, 4'b0000, 4'b0000, 0, 0,  0, 1, 0, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  0, 1, 0, 4'b0000, 4'b0000);
        // reserved address has no effect
        addv(1, 3, 4'b1111, 4'b0000, 0, 0,  0, 1, 0, 4'b0000, 4'b0000);
        addv(0, 0, 4'b0000, 4'b0000, 0, 0,  0, 1, 0, 4'b0000, 4'b0000);

        // ---- reset state ----
        cyc(2);
        chk("rst_itr", int'(itr_f), 0);
        chk("rst_busy", int'(busy_f), 0);
        chk("rst_id", int'(id_f), 0);
        chk("rst_pend", int'(pend_f), 0);
        chk("rst_mask", int'(mask_f), 15);
        rst = 0;
        cyc(1);

        // ---- vector table, applied to both instances ----
        foreach (vq[i]) begin
            cfg_wr = vq[i].wr; cfg_addr = vq[i].addr; cfg_data = vq[i].data;
            src = vq[i].s; itr_ack = vq[i].ack; itr_ret = vq[i].ret;
            cyc(1);
            chk($sformatf("vec%0d_itr_fix", i), int'(itr_f), int'(vq[i].e_itr));
            chk($sformatf("vec%0d_id_fix", i), int'(id_f), int'(vq[i].e_id));
            chk($sformatf("vec%0d_busy_fix", i), int'(busy_f), int'(vq[i].e_busy));
            chk($sformatf("vec%0d_pend_fix", i), int'(pend_f), int'(vq[i].e_pend));
            chk($sformatf("vec%0d_mask_fix", i), int'(mask_f), int'(vq[i].e_mask));
            chk($sformatf("vec%0d_itr_rr", i), int'(itr_r), int'(vq[i].e_itr));
            chk($sformatf("vec%0d_id_rr", i), int'(id_r), int'(vq[i].e_id));
            chk($sformatf("vec%0d_pend_rr", i), int'(pend_r), int'(vq[i].e_pend));
        end
        idle_inputs();

        // ---- fixed priority, simultaneous src[3]/src[1], ack+ret together, ret in REQ ----
        do_reset();
        cfg(2'd0, 4'b0000);
        cfg(2'd2, 4'b0001);
        pulse_src(4'b1010);
        wait_itr(0, "fix_first", 1);
        itr_ack = 1; itr_ret = 1;
        cyc(1);
        itr_ack = 0; itr_ret = 0;
        chk("ackret_itr", int'(itr_f), 0);
        chk("ackret_busy", int'(busy_f), 1);
        cyc(1);
        chk("ackret_still_serv", int'(busy_f), 1);
        pulse_ret();
        chk("gap_itr", int'(itr_f), 0);
        chk("gap_busy", int'(busy_f), 0);
        cyc(1);
        chk("gap_idle_itr", int'(itr_f), 0);
        wait_itr(0, "fix_second", 3);
        pulse_ret();
        chk("ret_in_req_itr", int'(itr_f), 1);
        pulse_ack();
        pulse_ret();
        cyc(3);

        // ---- round-robin order 0,1,2,3,0 with all sources kept pending ----
        do_reset();
        cfg(2'd0, 4'b0000);
        cfg(2'd2, 4'b0001);
        pulse_src(4'b1111);
        for (int g = 0; g < 5; g++) begin
            wait_itr(1, $sformatf("rr_grant%0d", g), g % 4);
            pulse_ack();
            pulse_src(4'(1 << (g % 4)));
            cyc(3);
            pulse_ret();
            chk($sformatf("rr_gap%0d", g), int'(itr_r), 0);
        end
        pulse_ack();
        pulse_ret();
        cyc(3);

        // ---- set wins over clear; edge during service re-requests ----
        do_reset();
        cfg(2'd0, 4'b0000);
        src = 4'b0001; cyc(1);
        src = 4'b0000; cyc(1);
        cfg(2'd1, 4'b0001);
        chk("set_wins_pend", int'(pend_f), 1);
        cfg(2'd1, 4'b0001);
        chk("w1c_pend", int'(pend_f), 0);
        cfg(2'd2, 4'b0001);
        pulse_src(4'b0001);
        wait_itr(0, "serv0", 0);
        pulse_ack();
        chk("serv0_pend_clr", int'(pend_f), 0);
        pulse_src(4'b0001);
        cyc(3);
        chk("nest_pend", int'(pend_f), 1);
        chk("nest_itr", int'(itr_f), 0);
        chk("nest_busy", int'(busy_f), 1);
        pulse_ret();
        chk("nest_gap_itr", int'(itr_f), 0);
        wait_itr(0, "rereq", 0);
        pulse_ack();
        pulse_ret();
        cyc(3);

        // ---- asynchronous reset during service ----
        do_reset();
        cfg(2'd0, 4'b0000);
        cfg(2'd2, 4'b0001);
        pulse_src(4'b0100);
        wait_itr(0, "pre_rst", 2);
        pulse_ack();
        pulse_src(4'b0010);
        cyc(3);
        chk("pre_rst_pend", int'(pend_f), 2);
        chk("pre_rst_busy", int'(busy_f), 1);
        rst = 1;
        #1;
        chk("async_rst_itr", int'(itr_f), 0);
        chk("async_rst_busy", int'(busy_f), 0);
        chk("async_rst_pend", int'(pend_f), 0);
        chk("async_rst_mask", int'(mask_f), 15);
        cyc(1);
        rst = 0;
        cyc(1);
        cfg(2'd0, 4'b0000);
        pulse_src(4'b0010);
        cyc(5);
        chk("rst_en_off_pend", int'(pend_f), 2);
        chk("rst_en_off_itr", int'(itr_f), 0);
        chk("rst_en_off_busy", int'(busy_f), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
